// File: rtl/anomaly_response_if.sv
// Handshake bundle between the anomaly detector / flush unit side (master) and
// anomaly_response_ctrl (slave).
interface anomaly_response_if #(
  parameter int unsigned CNT_W = 8
);
  logic             anomaly_in;
  logic             flush_ack;
  logic             clear_lockout;
  logic             flush_req;
  logic             stall_req;
  logic             lockout_out;
  logic [CNT_W-1:0] anomaly_count;
  logic [2:0]       state_out;

  modport master (
    output anomaly_in, flush_ack, clear_lockout,
    input  flush_req, stall_req, lockout_out, anomaly_count, state_out
  );

  modport slave (
    input  anomaly_in, flush_ack, clear_lockout,
    output flush_req, stall_req, lockout_out, anomaly_count, state_out
  );
endinterface

// File: rtl/anomaly_response_ctrl.sv
// Turns anomaly pulses into flush/stall actions with windowed escalation to a sticky lockout.
// Optional macro ANOMALY_TIMEOUT_EN: FLUSH gives up after FLUSH_TIMEOUT cycles and locks out.
module anomaly_response_ctrl #(
  parameter int unsigned STALL_CYCLES       = 4,
  parameter int unsigned COOLDOWN_CYCLES    = 8,
  parameter int unsigned WINDOW_CYCLES      = 64,
  parameter int unsigned ESCALATE_THRESHOLD = 3,
  parameter int unsigned CNT_W              = 8,
  parameter int unsigned FLUSH_TIMEOUT      = 16
) (
  input  logic               clk,
  input  logic               reset,
  anomaly_response_if.slave  bus
);

  localparam int unsigned PhMax = (STALL_CYCLES > COOLDOWN_CYCLES) ? STALL_CYCLES
                                                                   : COOLDOWN_CYCLES;
  localparam int unsigned PhW   = $clog2(PhMax + 1);
  localparam int unsigned TmrW  = $clog2(WINDOW_CYCLES);
  localparam int unsigned HitW  = $clog2(ESCALATE_THRESHOLD + 1);

  localparam logic [TmrW-1:0] TmrLast = TmrW'(WINDOW_CYCLES - 1);
  localparam logic [HitW-1:0] HitMax  = HitW'(ESCALATE_THRESHOLD);

  if (STALL_CYCLES < 1 || COOLDOWN_CYCLES < 1 || WINDOW_CYCLES < 2 ||
      (WINDOW_CYCLES & (WINDOW_CYCLES - 1)) != 0 || ESCALATE_THRESHOLD < 2 ||
      CNT_W < 1 || FLUSH_TIMEOUT < 1) begin : g_param_err
    $error("anomaly_response_ctrl: illegal parameter set");
  end

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StFlush    = 3'd1,
    StStall    = 3'd2,
    StCooldown = 3'd3,
    StLockout  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [PhW-1:0]   ph_cnt_q, ph_cnt_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic [HitW-1:0]  hits_q, hits_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             flush_req_q, stall_req_q, lockout_q;
  logic             clr_ok;

`ifdef ANOMALY_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(FLUSH_TIMEOUT + 1);
  logic [WaitW-1:0] wait_q, wait_d;
`endif

  always_comb begin
    state_d  = state_q;
    ph_cnt_d = ph_cnt_q;
    count_d  = count_q;
    tmr_d    = (tmr_q == TmrLast) ? '0 : tmr_q + 1'b1;
    clr_ok   = (state_q == StLockout) && bus.clear_lockout;

    if (bus.anomaly_in && count_q != '1) count_d = count_q + 1'b1;

    // A software clear wins over the window reload so the lockout cannot re-arm at once.
    if (clr_ok) begin
      hits_d = '0;
    end else if (tmr_q == TmrLast) begin
      hits_d = HitW'(bus.anomaly_in);
    end else if (bus.anomaly_in && hits_q != HitMax) begin
      hits_d = hits_q + 1'b1;
    end else begin
      hits_d = hits_q;
    end

`ifdef ANOMALY_TIMEOUT_EN
    wait_d = (state_q == StFlush) ? wait_q + 1'b1 : '0;
`endif

    case (state_q)
      StIdle: begin
        if (bus.anomaly_in) state_d = StFlush;
      end
      StFlush: begin
        if (bus.flush_ack) begin
          state_d  = StStall;
          ph_cnt_d = PhW'(STALL_CYCLES - 1);
        end
`ifdef ANOMALY_TIMEOUT_EN
        else if (wait_q == WaitW'(FLUSH_TIMEOUT - 1)) begin
          state_d = StLockout;
        end
`endif
      end
      StStall: begin
        if (ph_cnt_q == '0) begin
          state_d  = StCooldown;
          ph_cnt_d = PhW'(COOLDOWN_CYCLES - 1);
        end else begin
          ph_cnt_d = ph_cnt_q - 1'b1;
        end
      end
      StCooldown: begin
        if (ph_cnt_q == '0) begin
          state_d = bus.anomaly_in ? StFlush : StIdle;
        end else begin
          ph_cnt_d = ph_cnt_q - 1'b1;
        end
      end
      StLockout: begin
        if (bus.clear_lockout) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (hits_d == HitMax) state_d = StLockout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      ph_cnt_q    <= '0;
      tmr_q       <= '0;
      hits_q      <= '0;
      count_q     <= '0;
      flush_req_q <= 1'b0;
      stall_req_q <= 1'b0;
      lockout_q   <= 1'b0;
`ifdef ANOMALY_TIMEOUT_EN
      wait_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ph_cnt_q    <= ph_cnt_d;
      tmr_q       <= tmr_d;
      hits_q      <= hits_d;
      count_q     <= count_d;
      flush_req_q <= (state_d == StFlush);
      stall_req_q <= (state_d == StStall) || (state_d == StLockout);
      lockout_q   <= (state_d == StLockout);
`ifdef ANOMALY_TIMEOUT_EN
      wait_q      <= wait_d;
`endif
    end
  end

  assign bus.flush_req     = flush_req_q;
  assign bus.stall_req     = stall_req_q;
  assign bus.lockout_out   = lockout_q;
  assign bus.anomaly_count = count_q;
  assign bus.state_out     = state_q;

endmodule

// File: tb/tb_anomaly_response_ctrl.sv
// Self-checking bench: directed scenarios plus random stimulus against a
// queue-based behavioural model of anomaly_response_ctrl.
module tb_anomaly_response_ctrl;

  localparam int unsigned STALL_CYCLES       = 4;
  localparam int unsigned COOLDOWN_CYCLES    = 8;
  localparam int unsigned WINDOW_CYCLES      = 64;
  localparam int unsigned ESCALATE_THRESHOLD = 3;
  localparam int unsigned CNT_W              = 8;
  localparam int unsigned FLUSH_TIMEOUT      = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  anomaly_response_if #(.CNT_W(CNT_W)) bus ();
  anomaly_response_if #(.CNT_W(4))     bus2 ();

  anomaly_response_ctrl #(
    .STALL_CYCLES      (STALL_CYCLES),
    .COOLDOWN_CYCLES   (COOLDOWN_CYCLES),
    .WINDOW_CYCLES     (WINDOW_CYCLES),
    .ESCALATE_THRESHOLD(ESCALATE_THRESHOLD),
    .CNT_W             (CNT_W),
    .FLUSH_TIMEOUT     (FLUSH_TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Narrow counter, unreachable threshold: only anomaly_count saturation is of interest here.
  anomaly_response_ctrl #(
    .ESCALATE_THRESHOLD(255),
    .CNT_W             (4)
  ) dut2 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus2)
  );

  int nvec, nerr;
  bit chk_en;
  int m_state, m_left, m_wait, m_count, m_cnt2, edge_k;
  int hit_q[$];
  int flush_hi, stall_hi, cool_hi, lock_hi;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_left = 0; m_wait = 0; m_count = 0; m_cnt2 = 0; edge_k = 0;
    hit_q.delete();
  endtask

  // One clock edge of the reference: hits = anomalies in the current window since the last clear.
  task automatic model_step(input bit a, input bit ack, input bit clr, input bit a2);
    int  hits;
    int  cur;
    bit  cleared;
    cleared = (m_state == 4) && clr;
    cur     = (edge_k + 1) / WINDOW_CYCLES;
    if (cleared) hit_q.delete();
    else if (a) hit_q.push_back(edge_k);
    while (hit_q.size() > 0 && (hit_q[0] + 1) / WINDOW_CYCLES != cur) void'(hit_q.pop_front());
    hits = hit_q.size();
    if (a && m_count < (1 << CNT_W) - 1) m_count++;
    if (a2 && m_cnt2 < 15) m_cnt2++;
    case (m_state)
      0: if (a) begin m_state = 1; m_wait = 0; end
      1: begin
        if (ack) begin
          m_state = 2; m_left = STALL_CYCLES;
        end else begin
          m_wait++;
`ifdef ANOMALY_TIMEOUT_EN
          if (m_wait >= FLUSH_TIMEOUT) m_state = 4;
`endif
        end
      end
      2: begin
        m_left--;
        if (m_left == 0) begin m_state = 3; m_left = COOLDOWN_CYCLES; end
      end
      3: begin
        m_left--;
        if (m_left == 0) begin m_state = a ? 1 : 0; m_wait = 0; end
      end
      4: if (clr) m_state = 0;
      default: m_state = 0;
    endcase
    if (hits >= ESCALATE_THRESHOLD) m_state = 4;
    edge_k++;
  endtask

  task automatic step(input bit a, input bit ack, input bit clr, input bit a2);
    bus.anomaly_in    = a;
    bus.flush_ack     = ack;
    bus.clear_lockout = clr;
    bus2.anomaly_in   = a2;
    @(posedge clk);
    model_step(a, ack, clr, a2);
    #1;
    if (bus.flush_req)          flush_hi++;
    if (bus.stall_req)          stall_hi++;
    if (bus.lockout_out)        lock_hi++;
    if (bus.state_out == 3'd3)  cool_hi++;
  endtask

  task automatic apply_reset(input bit check_async);
    #2 reset = 1'b1;
    #1;
    if (check_async) begin
      check("rst_flush_req", bus.flush_req, 0);
      check("rst_stall_req", bus.stall_req, 0);
      check("rst_lockout",   bus.lockout_out, 0);
      check("rst_state",     bus.state_out, 0);
      check("rst_count",     bus.anomaly_count, 0);
    end
    model_reset();
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic clear_obs();
    flush_hi = 0; stall_hi = 0; cool_hi = 0; lock_hi = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("state_out",     bus.state_out, m_state);
      check("flush_req",     bus.flush_req, m_state == 1);
      check("stall_req",     bus.stall_req, m_state == 2 || m_state == 4);
      check("lockout_out",   bus.lockout_out, m_state == 4);
      check("anomaly_count", bus.anomaly_count, m_count);
      check("count_sat4",    bus2.anomaly_count, m_cnt2);
    end
  end

  initial begin
    nvec = 0; nerr = 0; chk_en = 0;
    bus.anomaly_in = 0; bus.flush_ack = 0; bus.clear_lockout = 0;
    bus2.anomaly_in = 0; bus2.flush_ack = 1; bus2.clear_lockout = 0;
    model_reset();
    clear_obs();
    apply_reset(1'b1);
    chk_en = 1;

    // Isolated anomaly, ack on the third FLUSH cycle, full stall/cooldown back to IDLE.
    clear_obs();
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (12) step(0, 0, 0, 0);
    check("t1_flush_cycles", flush_hi, 3);
    check("t1_stall_cycles", stall_hi, 4);
    check("t1_cool_cycles",  cool_hi, 8);
    check("t1_state_idle",   bus.state_out, 0);
    check("t1_count",        bus.anomaly_count, 1);
    check("t1_lockout",      lock_hi, 0);

    // Three anomalies five cycles apart escalate; clear returns to IDLE with hits cleared.
    apply_reset(1'b0);
    step(1, 1, 0, 0);
    repeat (4) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    repeat (4) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    check("t2_state_lock", bus.state_out, 4);
    check("t2_lockout",    bus.lockout_out, 1);
    check("t2_stall",      bus.stall_req, 1);
    check("t2_count",      bus.anomaly_count, 3);
    step(0, 1, 1, 0);
    check("t2_clr_state",  bus.state_out, 0);
    check("t2_clr_stall",  bus.stall_req, 0);
    check("t2_clr_lock",   bus.lockout_out, 0);
    step(1, 0, 0, 0);
    check("t2_reflush",    bus.state_out, 1);

    // Two anomalies, then the window wraps before the third: no escalation.
    apply_reset(1'b0);
    clear_obs();
    step(1, 1, 0, 0);
    repeat (5) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    repeat (70) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("t3_state_flush", bus.state_out, 1);
    check("t3_no_lockout",  lock_hi, 0);

    // Narrow counter saturates.
    apply_reset(1'b0);
    repeat (20) step(0, 0, 0, 1);
    check("t4_sat15", bus2.anomaly_count, 15);

`ifdef ANOMALY_TIMEOUT_EN
    apply_reset(1'b0);
    clear_obs();
    step(1, 0, 0, 0);
    repeat (16) step(0, 0, 0, 0);
    check("t6_timeout_flush", flush_hi, 16);
    check("t6_timeout_lock",  bus.state_out, 4);
`endif

    // Reset asserted while stalling clears everything asynchronously.
    apply_reset(1'b0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check("t5_in_stall", bus.state_out, 2);
    apply_reset(1'b1);

    repeat (3000) begin
      step(($urandom % 8) == 0, ($urandom % 3) == 0, ($urandom % 5) == 0, ($urandom % 2) == 0);
      if (($urandom % 400) == 0) apply_reset(1'b1);
    end

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/anomaly_response_ctrl.md
Name: anomaly_response_ctrl

Overview:
- Downstream consumer of the ALU-flag pattern detector's single-bit anomaly flag. It turns anomaly pulses into pipeline control actions.
- On an isolated anomaly it requests a pipeline flush, waits for the flush acknowledge, applies a fixed stall and then a cooldown.
- If anomalies recur too often within a sliding window, it escalates to a sticky lockout. The lockout holds the pipeline stalled until software clears it.
- Sits between the EX-stage pattern detector and the hazard/flush unit.

Parameters:
- STALL_CYCLES, 4: cycles stall_req is held after a flush ack (>=1).
- COOLDOWN_CYCLES, 8: cycles after a stall during which new anomalies do not trigger a flush (>=1).
- WINDOW_CYCLES, 64: length of the escalation window (power of 2, >=2).
- ESCALATE_THRESHOLD, 3: number of anomalies in one window that forces LOCKOUT (>=2).
- CNT_W, 8: width of the total anomaly counter.
- FLUSH_TIMEOUT, 16: maximum flush-ack wait; used only with ANOMALY_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- anomaly_in  input  1  anomaly flag from the pattern detector; sampled every cycle.
- flush_ack  input  1  flush unit acknowledge; meaningful only in FLUSH.
- clear_lockout  input  1  software clear; meaningful only in LOCKOUT.
- flush_req  output  1  flush request, held until acknowledged.
- stall_req  output  1  pipeline stall request.
- lockout_out  output  1  lockout status.
- anomaly_count  output  CNT_W  total anomalies since reset; saturating.
- state_out  output  3  current FSM state encoding.

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-high. All outputs are registered (Moore).
- Reset values:
  - state = IDLE (0).
  - flush_req, stall_req, lockout_out = 0.
  - anomaly_count = 0; window hit counter = 0; window timer = 0; stall/cooldown counter = 0.
- Reset asserted mid-operation aborts immediately to these values, including from LOCKOUT.
- State encodings: IDLE=0, FLUSH=1, STALL=2, COOLDOWN=3, LOCKOUT=4. Values 5-7 are illegal and recover to IDLE on the next edge.
- Counting, in every state including LOCKOUT: each cycle anomaly_in=1 increments anomaly_count, saturating at all-ones. It also increments window_hits, saturating at ESCALATE_THRESHOLD.
- Window:
  - The window timer is free-running, counting 0..WINDOW_CYCLES-1 and wrapping.
  - On a wrap cycle, window_hits reloads to 1 if anomaly_in=1 that cycle, otherwise to 0.
  - clear_lockout accepted in LOCKOUT also resets window_hits to 0. The timer is unaffected.
- Escalation has highest priority. If the next value of window_hits equals ESCALATE_THRESHOLD, the next state is LOCKOUT from any state. This overrides flush_ack and any counter expiry in the same cycle.
- IDLE: anomaly_in=1 → FLUSH. flush_req is visible in the first cycle after the sampling edge (1-cycle latency).
- FLUSH:
  - flush_req=1 is held while waiting.
  - flush_ack=1 → STALL, with the counter loaded to STALL_CYCLES-1.
  - Anomalies arriving here are counted only.
- STALL: stall_req=1 for exactly STALL_CYCLES cycles, then → COOLDOWN with the counter loaded to COOLDOWN_CYCLES-1.
- COOLDOWN:
  - All control outputs are 0. Anomalies are counted, but no flush is issued.
  - On expiry → IDLE. If anomaly_in=1 on the expiry cycle, go directly to FLUSH instead.
- LOCKOUT:
  - stall_req=1, lockout_out=1, flush_req=0.
  - clear_lockout=1 → IDLE. An anomaly on the same cycle is counted, but does not re-enter FLUSH.
- flush_ack outside FLUSH and clear_lockout outside LOCKOUT are ignored.

Optional Feature:
- Macro: ANOMALY_TIMEOUT_EN.
- Defined: a wait counter runs in FLUSH. If no flush_ack arrives within FLUSH_TIMEOUT cycles of entering FLUSH, the next state is LOCKOUT. flush_ack in the same cycle as the timeout wins.
- Not defined: FLUSH waits indefinitely and the wait counter logic is absent.

Test Plan:
- Default params. After reset, anomaly_in=1 for one cycle (edge E), flush_ack=1 on the 3rd FLUSH cycle → flush_req high 3 cycles, stall_req high 4 cycles, 8 cooldown cycles, then IDLE; anomaly_count=1, lockout_out=0.
- Three single-cycle anomalies 5 cycles apart within one window (flush_ack tied 1) → state=4, lockout_out=1, stall_req=1 after the 3rd anomaly's edge; count=3.
- Then hold clear_lockout=1 for 1 cycle → IDLE, stall_req=0, lockout_out=0. One further anomaly → FLUSH, not LOCKOUT (window_hits was cleared).
- Two anomalies, idle 70 cycles across the window wrap, one more anomaly → normal FLUSH path, no LOCKOUT.
- CNT_W=4, ESCALATE_THRESHOLD=255 override, anomaly_in held high 20 cycles → anomaly_count sticks at 15.
- With ANOMALY_TIMEOUT_EN, FLUSH_TIMEOUT=16, anomaly then flush_ack held 0 → LOCKOUT after 16 FLUSH cycles. Reset asserted during STALL → all outputs 0 asynchronously.
